// File: rtl/eth_sched_pkg.sv
// Shared types and helpers for the Ethernet WRR frame scheduler.
package eth_sched_pkg;

    localparam int MAX_REQS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } sched_state_t;

    // Callers slice the low NUM_REQS bits of the result.
    function automatic logic [MAX_REQS-1:0] onehot(input int unsigned index);
        return MAX_REQS'(1) << index;
    endfunction

endpackage

// File: rtl/eth_wrr_frame_scheduler_if.sv
// Request/grant bundle between frame sources and the TX mux scheduler.
interface eth_wrr_frame_scheduler_if #(
    parameter int NUM_REQS = 4,
    parameter int INDEXW   = $clog2(NUM_REQS)
);
    logic [NUM_REQS-1:0] req;
    logic [NUM_REQS-1:0] frame_done;
    logic [NUM_REQS-1:0] grant;
    logic                grant_valid;
    logic [INDEXW-1:0]   grant_index;

    modport master (
        input  req,
        input  frame_done,
        output grant,
        output grant_valid,
        output grant_index
    );

    modport slave (
        output req,
        output frame_done,
        input  grant,
        input  grant_valid,
        input  grant_index
    );
endinterface

// File: rtl/eth_rr_pick.sv
// Round-robin picker: first eligible index after ptr, wrapping back to ptr itself.
module eth_rr_pick #(
    parameter int NUM_REQS = 4,
    parameter int INDEXW   = $clog2(NUM_REQS)
) (
    input  logic [NUM_REQS-1:0] eligible,
    input  logic [INDEXW-1:0]   ptr,
    output logic [INDEXW-1:0]   sel,
    output logic                any
);
    // One extra bit covers every position of the doubled vector (up to 2*NUM_REQS-1).
    localparam int SELW = INDEXW + 1;

    logic [2*NUM_REQS-1:0] doubled;
    logic [NUM_REQS-1:0]   rotated;
    logic [SELW-1:0]       start;
    logic [SELW-1:0]       offset;
    logic [SELW-1:0]       pos;

    assign doubled = {eligible, eligible};
    assign start   = SELW'(ptr) + SELW'(1);
    assign any     = |eligible;

    generate
        for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_rotate
            assign rotated[gi] = doubled[start + SELW'(gi)];
        end
    endgenerate

    always_comb begin
        offset = '0;
        for (int i = NUM_REQS - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = SELW'(i);
            end
        end
    end

    assign pos = start + offset;
    assign sel = (pos >= SELW'(NUM_REQS)) ? INDEXW'(pos - SELW'(NUM_REQS)) : INDEXW'(pos);

endmodule

// File: rtl/eth_wrr_frame_scheduler.sv
// Frame-level weighted round-robin grant generator for the shared MAC TX mux.
module eth_wrr_frame_scheduler
    import eth_sched_pkg::*;
#(
    parameter int NUM_REQS   = 4,
    parameter int WEIGHTW    = 4,
    parameter int GAP_CYCLES = 2,
    parameter int INDEXW     = $clog2(NUM_REQS)
) (
    input  logic                        clk,
    input  logic                        reset,
    eth_wrr_frame_scheduler_if.master   sched,
    input  logic                        cfg_enable,
    input  logic [NUM_REQS*WEIGHTW-1:0] cfg_weight,
    output logic [WEIGHTW-1:0]          credit,
    output logic                        busy
);
    // A zero gap still costs one GAP cycle so grant-low time is max(GAP_CYCLES,1)+1.
    localparam int GAP_LOAD = (GAP_CYCLES > 1) ? GAP_CYCLES - 1 : 0;
    localparam int GAPW     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    sched_state_t        state_reg;
    logic [INDEXW-1:0]   ptr_reg;
    logic [WEIGHTW-1:0]  credit_reg;
    logic [GAPW-1:0]     gap_reg;
    logic [NUM_REQS-1:0] grant_reg;
    logic                grant_valid_reg;
    logic [INDEXW-1:0]   grant_index_reg;
    logic                busy_reg;

    logic [NUM_REQS-1:0] eligible;
    logic [INDEXW-1:0]   sel;
    logic                any;
    logic                reuse;
    logic [INDEXW-1:0]   pick_idx;
    logic [MAX_REQS-1:0] pick_onehot;
    logic [NUM_REQS-1:0] pick_grant;
    logic [WEIGHTW-1:0]  weight_sel;

    generate
        for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_eligible
            assign eligible[gi] = sched.req[gi] & (cfg_weight[gi*WEIGHTW +: WEIGHTW] != '0);
        end
    endgenerate

    eth_rr_pick #(
        .NUM_REQS (NUM_REQS),
        .INDEXW   (INDEXW)
    ) u_pick (
        .eligible (eligible),
        .ptr      (ptr_reg),
        .sel      (sel),
        .any      (any)
    );

    // Stay with the current source while it has credit left and still wants the link.
    always_comb begin
        reuse       = (credit_reg != '0) && eligible[ptr_reg];
        pick_idx    = reuse ? ptr_reg : sel;
        pick_onehot = onehot(32'(pick_idx));
        pick_grant  = pick_onehot[NUM_REQS-1:0];
        weight_sel  = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (sel == INDEXW'(i)) begin
                weight_sel = cfg_weight[i*WEIGHTW +: WEIGHTW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            ptr_reg         <= '0;
            credit_reg      <= '0;
            gap_reg         <= '0;
            grant_reg       <= '0;
            grant_valid_reg <= 1'b0;
            grant_index_reg <= '0;
            busy_reg        <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cfg_enable && any) begin
                        grant_reg       <= pick_grant;
                        grant_valid_reg <= 1'b1;
                        grant_index_reg <= pick_idx;
                        busy_reg        <= 1'b1;
                        state_reg       <= BUSY;
                        if (!reuse) begin
                            ptr_reg    <= sel;
                            credit_reg <= weight_sel;
                        end
                    end
                end
                BUSY: begin
                    if (sched.frame_done[grant_index_reg]) begin
                        grant_reg       <= '0;
                        grant_valid_reg <= 1'b0;
                        if (credit_reg != '0) begin
                            credit_reg <= credit_reg - WEIGHTW'(1);
                        end
                        gap_reg   <= GAPW'(GAP_LOAD);
                        state_reg <= GAP;
                    end
                end
                GAP: begin
                    if (gap_reg == '0) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        gap_reg <= gap_reg - GAPW'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign sched.grant       = grant_reg;
    assign sched.grant_valid = grant_valid_reg;
    assign sched.grant_index = grant_index_reg;
    assign credit            = credit_reg;
    assign busy              = busy_reg;

endmodule
